// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing for the FIFO burst reader and its output buffer.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(BUF_DEPTH);

  // Buffer depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Small in-order output buffer: register array with wrap-around pointers.
module fifo_out_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;

  // The owner never pushes into a full buffer nor pops an empty one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_WIDTH'(1);
        2'b01:   count <= count - OCC_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a 1-cycle-latency FIFO onto a valid/ready stream.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  xfer_count
);

  state_t                state;
  state_t                state_next;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  latched_len;
  logic                  rd_inflight;
  logic                  pop;
  logic [OCC_WIDTH-1:0]  buf_count;
  logic [OCC_WIDTH-1:0]  occ;
  logic [DATA_WIDTH-1:0] head_data;

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  // Credit check counts the in-flight read so captured data always has a slot;
  // it deliberately ignores this cycle's pop to keep m_ready off the read path.
  always_comb begin
    occ          = buf_count + OCC_WIDTH'(rd_inflight);
    fifo_read_en = (state == FETCH) && (remaining != '0) && !fifo_empty &&
                   (occ < OCC_WIDTH'(BUF_DEPTH));
    m_valid      = (buf_count != '0);
    pop          = m_valid && m_ready;
    m_data       = m_valid ? head_data : '0;
    m_last       = m_valid && (xfer_count == latched_len - LEN_WIDTH'(1));
    busy         = (state != IDLE);
    done         = (state == DONE);
    state_next   = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (burst_len != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (fifo_read_en && (remaining == LEN_WIDTH'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      latched_len <= '0;
      xfer_count  <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_next;
      rd_inflight <= fifo_read_en;
      if ((state == IDLE) && start) begin
        remaining   <= burst_len;
        latched_len <= burst_len;
        xfer_count  <= '0;
      end else begin
        if (fifo_read_en) begin
          remaining <= remaining - LEN_WIDTH'(1);
        end
        if (pop) begin
          xfer_count <= xfer_count + LEN_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, directed scenarios and random bursts
// checked against an in-order word queue model.
module tb_fifo_burst_reader;

  localparam int DW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [LW-1:0] xfer_count;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fifo_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] ref_q[$];
  int            exp_len = 0;
  int            exp_idx = 0;
  int            rd_count = 0;
  int            viol_rd = 0, viol_stable = 0, viol_last = 0, viol_xc = 0, viol_extra = 0;
  logic          prev_stalled = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          done_seen = 1'b0;
  logic [63:0]   seq_acc = '0;
  logic [DW-1:0] last_word = '0;

  logic          obs_rd, obs_valid, obs_last, obs_busy, obs_done;
  logic [DW-1:0] obs_data;
  logic [LW-1:0] obs_xc;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .burst_len    (burst_len),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .xfer_count   (xfer_count)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO with registered read data
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read_en && (fifo_q.size() != 0)) begin
        fifo_data <= fifo_q.pop_front();
      end
      if (wr_en) begin
        fifo_q.push_back(wr_data);
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle: observe outputs at the falling edge, drive inputs, advance the model
  task automatic applyStimulus(input logic r, input logic st, input logic [LW-1:0] len,
                               input logic rdy, input logic wr, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_word;
    @(negedge clk);
    obs_rd    = fifo_read_en;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_last  = m_last;
    obs_busy  = busy;
    obs_done  = done;
    obs_xc    = xfer_count;
    rst       = r;
    start     = st;
    burst_len = len;
    m_ready   = rdy;
    wr_en     = wr;
    wr_data   = wd;
    if (r) begin
      ref_q.delete();
      exp_len      = 0;
      exp_idx      = 0;
      rd_count     = 0;
      prev_stalled = 1'b0;
    end else begin
      if (obs_rd && fifo_empty) viol_rd++;
      if (obs_last && !obs_valid) viol_last++;
      if (int'(obs_xc) != exp_idx) viol_xc++;
      if (prev_stalled && (!obs_valid || obs_data !== prev_data || obs_last !== prev_last))
        viol_stable++;
      if (obs_rd) rd_count++;
      if (obs_valid && rdy) begin
        if (ref_q.size() == 0) begin
          viol_extra++;
        end else begin
          exp_word = ref_q.pop_front();
          checkOutput("m_data", obs_data, exp_word);
        end
        checkOutput("m_last", obs_last, (exp_idx == exp_len - 1));
        seq_acc = {seq_acc[59:0], obs_data};
        if (obs_last) last_word = obs_data;
        exp_idx++;
      end
      prev_stalled = obs_valid && !rdy;
      prev_data    = obs_data;
      prev_last    = obs_last;
      if (obs_done) begin
        checkOutput("done_xfers", exp_idx, exp_len);
        checkOutput("done_reads", rd_count, exp_len);
        done_seen = 1'b1;
      end
      if (st && !obs_busy) begin
        exp_len  = int'(len);
        exp_idx  = 0;
        rd_count = 0;
      end
      if (wr) ref_q.push_back(wd);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic runToDone(input int budget);
    for (int c = 0; c < budget; c++) begin
      idleCycle();
      if (done_seen) break;
    end
  endtask

  initial begin
    logic [15:0]   rd_m, v_m, l_m, d_m;
    logic [DW-1:0] late[3];
    int            rd_win;
    late = '{4'h9, 4'hB, 4'hD};

    // Reset with random inputs, start held high
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'b1, LW'($urandom), 1'($urandom), 1'b0, DW'($urandom));
    idleCycle();
    checkOutput("reset_outputs", {obs_rd, obs_valid, obs_data, obs_last, obs_busy, obs_done, obs_xc}, '0);
    idleCycle();
    checkOutput("reset_start_ignored", obs_busy, 1'b0);

    // Burst of 4 with no stalls: exact cycle timing
    for (int w = 1; w <= 4; w++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, DW'(w));
    seq_acc = '0; rd_m = '0; v_m = '0; l_m = '0; d_m = '0;
    applyStimulus(1'b0, 1'b1, LW'(4), 1'b1, 1'b0, '0);
    for (int c = 1; c <= 8; c++) begin
      idleCycle();
      rd_m[c] = obs_rd;
      v_m[c]  = obs_valid;
      l_m[c]  = obs_last;
      d_m[c]  = obs_done;
    end
    checkOutput("t2_read_cycles", rd_m, 16'h001E);
    checkOutput("t2_valid_cycles", v_m, 16'h0078);
    checkOutput("t2_last_cycles", l_m, 16'h0040);
    checkOutput("t2_done_cycles", d_m, 16'h0080);
    checkOutput("t2_data_seq", seq_acc, 64'h1234);
    checkOutput("t2_xfer_count", obs_xc, 5'd4);

    // Backpressure: burst of 6, consumer stalled in cycles 2..9
    for (int w = 0; w < 6; w++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, DW'(10 + w));
    seq_acc = '0; done_seen = 1'b0; rd_win = 0;
    applyStimulus(1'b0, 1'b1, LW'(6), 1'b1, 1'b0, '0);
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b0, 1'b0, '0, !(c >= 2 && c <= 9), 1'b0, '0);
      if (c <= 9 && obs_rd) rd_win++;
      if (done_seen) break;
    end
    checkOutput("t3_reads_while_stalled", rd_win, 3);
    checkOutput("t3_data_seq", seq_acc, 64'hABCDEF);
    checkOutput("t3_done_seen", done_seen, 1'b1);

    // Underrun: 2 words ready, 3 more arrive from cycle 4
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'h3);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'h7);
    seq_acc = '0; done_seen = 1'b0; last_word = '0;
    applyStimulus(1'b0, 1'b1, LW'(5), 1'b1, 1'b0, '0);
    for (int c = 1; c <= 40; c++) begin
      if (c >= 4 && c <= 6) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, late[c-4]);
      else idleCycle();
      if (done_seen) break;
    end
    checkOutput("t4_data_seq", seq_acc, 64'h379BD);
    checkOutput("t4_last_word", last_word, 4'hD);
    checkOutput("t4_done_seen", done_seen, 1'b1);

    // Zero-length burst
    rd_m = '0;
    applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b0, '0);
    idleCycle();
    checkOutput("t5_busy_done_c1", {obs_busy, obs_done}, 2'b11);
    rd_m[0] = obs_rd | obs_valid;
    idleCycle();
    checkOutput("t5_idle_c2", obs_busy, 1'b0);
    rd_m[1] = obs_rd | obs_valid;
    checkOutput("t5_no_activity", rd_m, '0);

    // Reset after two transfers, then a fresh burst of 2
    for (int w = 0; w < 6; w++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, DW'(w + 1));
    applyStimulus(1'b0, 1'b1, LW'(6), 1'b1, 1'b0, '0);
    for (int c = 0; c < 20; c++) begin
      idleCycle();
      if (exp_idx == 2) break;
    end
    checkOutput("t6_two_xfers", exp_idx, 2);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    idleCycle();
    checkOutput("t6_reset_outputs", {obs_rd, obs_valid, obs_data, obs_last, obs_busy, obs_done, obs_xc}, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'hC);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'h5);
    seq_acc = '0; done_seen = 1'b0;
    applyStimulus(1'b0, 1'b1, LW'(2), 1'b1, 1'b0, '0);
    runToDone(30);
    checkOutput("t6_done_seen", done_seen, 1'b1);
    checkOutput("t6_data_seq", seq_acc, 64'hC5);
    idleCycle();
    checkOutput("t6_xfer_count", obs_xc, 5'd2);

    // Random bursts with random writes, stalls and stray starts
    for (int b = 0; b < 25; b++) begin
      done_seen = 1'b0;
      applyStimulus(1'b0, 1'b1, LW'($urandom_range(0, 20)), ($urandom % 4) != 0,
                    1'($urandom), DW'($urandom));
      for (int c = 0; c < 500; c++) begin
        applyStimulus(1'b0, ($urandom % 3) == 0, LW'($urandom), ($urandom % 4) != 0,
                      1'($urandom), DW'($urandom));
        if (done_seen) break;
      end
      checkOutput("rand_done_seen", done_seen, 1'b1);
    end

    checkOutput("read_while_empty", viol_rd, 0);
    checkOutput("stall_stability", viol_stable, 0);
    checkOutput("last_without_valid", viol_last, 0);
    checkOutput("xfer_count_track", viol_xc, 0);
    checkOutput("unexpected_words", viol_extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's synchronous FIFO. On a start command it drains exactly burst_len words from the FIFO through the FIFO's read_en/empty/data_out interface. That interface has one cycle of read latency. Words are re-presented on a valid/ready output stream with a last marker. It sits between the FIFO and any downstream consumer that applies backpressure.

Parameters:
- DATA_WIDTH, 4, width of a FIFO word and of m_data.
- LEN_WIDTH, 5, width of burst_len and xfer_count; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- burst_len  input  LEN_WIDTH  number of words to read; sampled with start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_read_en.
- fifo_read_en  output  1  read strobe to FIFO.
- m_valid  output  1  output word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_WIDTH  output word.
- m_last  output  1  qualifies the final word of the burst.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at burst completion.
- xfer_count  output  LEN_WIDTH  words accepted downstream in the current or most recent burst.

Behaviour:
- Reset: state=IDLE; buffer, in-flight flag and all counters cleared. fifo_read_en, m_valid, m_data, m_last, busy, done and xfer_count all read 0 the cycle after rst is sampled. Reset overrides every other input and is legal mid-burst; any in-flight FIFO data is discarded.
- Output handshake: a word transfers on a cycle with m_valid && m_ready.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid never drops without a transfer.
- Internal 3-entry in-order output buffer (BUF_DEPTH=3).
  - occ = buffered entries + (read issued last cycle ? 1 : 0), range 0..3.
- fifo_read_en = (state==FETCH) && (remaining!=0) && !fifo_empty && (occ<BUF_DEPTH).
  - No combinational path from m_ready to fifo_read_en.
- Data capture: fifo_data is written to the buffer tail on the edge ending the cycle after each fifo_read_en cycle, unconditionally. Credit accounting guarantees space.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle in steady state.
- States:
  - IDLE: start=1 latches remaining=burst_len and clears xfer_count.
    - burst_len!=0 -> FETCH.
    - burst_len==0 -> DONE; no reads issued.
    - start while busy is ignored.
  - FETCH: issue reads per the rule above; remaining decrements on each fifo_read_en. When remaining reaches 0 -> DRAIN.
  - DRAIN: no reads. When occ==0 and the final transfer has occurred -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- xfer_count increments on each output transfer and holds its value in IDLE until the next accepted start.
- m_last = m_valid && (xfer_count == latched_len-1).
- FIFO empty mid-burst: reads pause with no bubble words; they resume the first cycle fifo_empty=0.
- Latency: start sampled in cycle T -> first fifo_read_en in T+1 -> first m_valid in T+3.
- Wrap-around: counters never wrap within a burst because remaining is bounded by burst_len.

Decomposition:
- Package fifo_burst_reader_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - localparam BUF_DEPTH=3;
  - the occ width, $clog2(BUF_DEPTH+1).
- One sub-module, fifo_out_buf: 3-entry in-order buffer with push/pop, head data and count. It is a plain register array with wrap-around pointers.

Test Plan:
1. Reset: hold rst 2 cycles with random inputs -> all outputs 0, busy=0; start during rst is ignored.
2. Burst 4, FIFO preloaded 0x1,0x2,0x3,0x4, m_ready=1, start in cycle 0:
   - fifo_read_en in cycles 1-4;
   - m_data 1,2,3,4 in cycles 3-6, with m_last only in cycle 6;
   - done in cycle 7; xfer_count=4.
3. Backpressure: burst 6, FIFO holds 0xA..0xF, m_ready=0 for cycles 2-9:
   - exactly 3 reads issued, then fifo_read_en=0;
   - after release, words A..F delivered in order, none lost or duplicated;
   - m_data stable while stalled.
4. FIFO underrun: burst 5 with 2 words preloaded (0x3,0x7), then 0x9,0xB,0xD written 4 cycles later -> fifo_read_en never high while fifo_empty=1; output is 3,7,9,B,D with m_last on D.
5. Zero-length: start with burst_len=0 -> busy=1 in cycle 1, done=1 in cycle 1, IDLE in cycle 2; no fifo_read_en, no m_valid.
6. Reset mid-burst: burst 6, assert rst after 2 transfers -> outputs 0 next cycle; then a new burst of 2 on a re-filled FIFO completes normally with xfer_count=2.
